// File: rtl/rca_bist_ctrl_if.sv
// Bundle of control, status and adder-datapath signals for the rca_bist_ctrl BIST controller.
// The signature output exists only when RCA_BIST_SIG_EN is defined.
interface rca_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic [4:0] sum_in;
    logic       cout_in;
    logic [4:0] a;
    logic [4:0] b;
    logic       c_1;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] fail_mask;
    logic [7:0] err_count;
`ifdef RCA_BIST_SIG_EN
    logic [15:0] signature;
`endif

    // master is the BIST controller; slave is the system control plus adder under test
    modport master (
`ifdef RCA_BIST_SIG_EN
        output signature,
`endif
        input  start,
        input  abort,
        input  sum_in,
        input  cout_in,
        output a,
        output b,
        output c_1,
        output busy,
        output done,
        output pass,
        output fail_mask,
        output err_count
    );

    modport slave (
`ifdef RCA_BIST_SIG_EN
        input  signature,
`endif
        output start,
        output abort,
        output sum_in,
        output cout_in,
        input  a,
        input  b,
        input  c_1,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask,
        input  err_count
    );
endinterface

// File: rtl/rca_bist_ctrl.sv
// BIST controller for a 5-bit ripple-carry adder: 8-vector sweeps, golden compare, fault mask/count.
// Optional MISR response signature is enabled by defining RCA_BIST_SIG_EN.
module rca_bist_ctrl #(
    parameter int RESP_LAT   = 1,
    parameter int NUM_PASSES = 1
) (
    input  logic          clk,
    input  logic          init,
    rca_bist_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int             HW         = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
    localparam logic [HW-1:0]  HOLD_LAST  = HW'(RESP_LAT - 1);
    localparam logic [3:0]     PASS_LAST  = 4'(NUM_PASSES - 1);

    state_t        state_q, state_d;
    logic [2:0]    d_q, d_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    pass_cnt_q, pass_cnt_d;
    logic [5:0]    fail_mask_q, fail_mask_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          pass_q, pass_d;
`ifdef RCA_BIST_SIG_EN
    logic [15:0]   sig_q, sig_d;
`endif

    logic [4:0] vec_a, vec_b;
    logic       vec_c;
    logic       a1, b1;
    logic [5:0] expected;
    logic [5:0] mismatch;
    logic [5:0] mask_next;
    logic       sample;

    // Operands are a pure function of the vector index; they are forced to zero outside RUN
    always_comb begin
        a1 = (~d_q[1] & (d_q[2] | d_q[0])) | (d_q[2] & d_q[0]);
        b1 = (~d_q[0] & (d_q[2] | d_q[1])) | (d_q[2] & d_q[1]);
        vec_a = '0;
        vec_b = '0;
        vec_c = 1'b0;
        if (state_q == RUN) begin
            vec_a = {d_q[1], a1, d_q[1], a1, d_q[2]};
            vec_b = {d_q[0], b1, d_q[0], b1, d_q[1]};
            vec_c = d_q[0];
        end
    end

    always_comb begin
        expected  = {1'b0, vec_a} + {1'b0, vec_b} + {5'b0, vec_c};
        mismatch  = expected ^ {bus.cout_in, bus.sum_in};
        mask_next = fail_mask_q | mismatch;
        sample    = (state_q == RUN) && !bus.abort && (hold_q == HOLD_LAST);
    end

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        hold_d      = hold_q;
        pass_cnt_d  = pass_cnt_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;
`ifdef RCA_BIST_SIG_EN
        sig_d       = sig_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d     = RUN;
                    d_d         = '0;
                    hold_d      = '0;
                    pass_cnt_d  = '0;
                    fail_mask_d = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
`ifdef RCA_BIST_SIG_EN
                    sig_d       = 16'hFFFF;
`endif
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (sample) begin
                    hold_d      = '0;
                    fail_mask_d = mask_next;
                    if ((mismatch != 6'd0) && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
`ifdef RCA_BIST_SIG_EN
                    sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[11] ^ sig_q[4]}
                            ^ {10'b0, bus.cout_in, bus.sum_in};
`endif
                    // The 3-bit index wraps to 0 on its own when a sweep repeats
                    d_d = d_q + 3'd1;
                    if (d_q == 3'd7) begin
                        if (pass_cnt_q == PASS_LAST) begin
                            state_d = DONE;
                            pass_d  = (mask_next == 6'd0);
                        end else begin
                            pass_cnt_d = pass_cnt_q + 4'd1;
                        end
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state_q     <= IDLE;
            d_q         <= '0;
            hold_q      <= '0;
            pass_cnt_q  <= '0;
            fail_mask_q <= '0;
            err_count_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            hold_q      <= hold_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

`ifdef RCA_BIST_SIG_EN
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign bus.signature = sig_q;
`endif

    assign bus.a         = vec_a;
    assign bus.b         = vec_b;
    assign bus.c_1       = vec_c;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.err_count = err_count_q;

endmodule
